// File: rtl/alu_pkg.sv
// Shared definitions for the wide adder sequencer and its slice adder.
// Holds the slice width and the sequencer state encoding.
package alu_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seq_state_t;

endpackage

// File: rtl/rca.sv
// 16-bit ripple-carry adder slice.
// Also exposes the carry into the MSB so callers can derive signed overflow.
module rca
    import alu_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] sum,
    output logic              cout,
    output logic              msbcin
);

    logic [WORD_W-1:0] low;
    logic [1:0]        top;

    // Add the low 15 bits first; bit 15 of that partial sum is the carry into the MSB
    assign low = {1'b0, a[WORD_W-2:0]} + {1'b0, b[WORD_W-2:0]} + WORD_W'(cin);

    // MSB column uses the carry produced by the lower bits
    assign top = {1'b0, a[WORD_W-1]} + {1'b0, b[WORD_W-1]} + {1'b0, low[WORD_W-1]};

    assign sum    = {top[0], low[WORD_W-2:0]};
    assign cout   = top[1];
    assign msbcin = low[WORD_W-1];

endmodule

// File: rtl/wide_add_seq.sv
// Multi-cycle wide adder/subtractor: one 16-bit slice per cycle, LSW first,
// carry chained through a register, result and ALU flags over valid/ready.
module wide_add_seq
    import alu_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic                    op_sub,
    input  logic [WORD_W*WORDS-1:0] a,
    input  logic [WORD_W*WORDS-1:0] b,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [WORD_W*WORDS-1:0] result,
    output logic                    flag_c,
    output logic                    flag_v,
    output logic                    flag_z,
    output logic                    flag_n,
    output logic                    busy
);

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

    seq_state_t state;

    logic [WORDS-1:0][WORD_W-1:0] a_r;
    logic [WORDS-1:0][WORD_W-1:0] b_r;
    logic [WORDS-1:0][WORD_W-1:0] acc;
    logic [WORDS-1:0][WORD_W-1:0] acc_next;

    logic [IDX_W-1:0] idx;
    logic             carry;
    logic             zacc;

    logic [WORD_W-1:0] sum;
    logic              cout;
    logic              msbcin;

    rca u_rca (
        .a      (a_r[idx]),
        .b      (b_r[idx]),
        .cin    (carry),
        .sum    (sum),
        .cout   (cout),
        .msbcin (msbcin)
    );

    // Working accumulator with the current slice merged in; published only at the end
    // so the visible result never shows a partially built value
    always_comb begin
        acc_next      = acc;
        acc_next[idx] = sum;
    end

    // Sequencer FSM with registered handshake outputs, operand/result and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            start_ready <= 1'b1;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            result      <= '0;
            flag_c      <= 1'b0;
            flag_v      <= 1'b0;
            flag_z      <= 1'b0;
            flag_n      <= 1'b0;
            idx         <= '0;
            carry       <= 1'b0;
            zacc        <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            acc         <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_r         <= a;
                        b_r         <= op_sub ? ~b : b;
                        carry       <= op_sub;
                        idx         <= '0;
                        zacc        <= 1'b1;
                        state       <= RUN;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    carry <= cout;
                    zacc  <= zacc & (sum == '0);
                    if (idx == LAST) begin
                        result    <= acc_next;
                        flag_c    <= cout;
                        flag_v    <= cout ^ msbcin;
                        flag_z    <= zacc & (sum == '0);
                        flag_n    <= sum[WORD_W-1];
                        idx       <= '0;
                        state     <= DONE;
                        res_valid <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state       <= IDLE;
                        res_valid   <= 1'b0;
                        busy        <= 1'b0;
                        start_ready <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    start_ready <= 1'b1;
                    res_valid   <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq (WORDS=4 and WORDS=1 instances).
// Expected values come from constants and a plain-arithmetic reference model.
module tb_wide_add_seq;

    logic        clk;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic        op_sub;
    logic [63:0] a;
    logic [63:0] b;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] result;
    logic        flag_c;
    logic        flag_v;
    logic        flag_z;
    logic        flag_n;
    logic        busy;

    logic        s_start_valid;
    logic        s_start_ready;
    logic        s_op_sub;
    logic [15:0] s_a;
    logic [15:0] s_b;
    logic        s_res_valid;
    logic        s_res_ready;
    logic [15:0] s_result;
    logic        s_flag_c;
    logic        s_flag_v;
    logic        s_flag_z;
    logic        s_flag_n;
    logic        s_busy;

    int errors = 0;
    int checks = 0;

    wide_add_seq #(.WORDS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_sub      (op_sub),
        .a           (a),
        .b           (b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .flag_c      (flag_c),
        .flag_v      (flag_v),
        .flag_z      (flag_z),
        .flag_n      (flag_n),
        .busy        (busy)
    );

    wide_add_seq #(.WORDS(1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .start_valid (s_start_valid),
        .start_ready (s_start_ready),
        .op_sub      (s_op_sub),
        .a           (s_a),
        .b           (s_b),
        .res_valid   (s_res_valid),
        .res_ready   (s_res_ready),
        .result      (s_result),
        .flag_c      (s_flag_c),
        .flag_v      (s_flag_v),
        .flag_z      (s_flag_z),
        .flag_n      (s_flag_n),
        .busy        (s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: 64-bit two's complement add/sub; flags returned as {c,v,z,n}
    task automatic model(input logic [63:0] x, input logic [63:0] y,
                         input logic sub,
                         output logic [63:0] r, output logic [3:0] f);
        logic [64:0] wide;
        logic c, v;
        if (sub) begin
            r = x - y;
            c = (x >= y);
            v = (x[63] != y[63]) && (r[63] != x[63]);
        end else begin
            wide = {1'b0, x} + {1'b0, y};
            r = wide[63:0];
            c = wide[64];
            v = (x[63] == y[63]) && (r[63] != x[63]);
        end
        f = {c, v, (r == 64'd0), r[63]};
    endtask

    // Issue one op on the WORDS=4 instance, wait for the result, then complete the handshake
    task automatic run_op(input logic [63:0] x, input logic [63:0] y,
                          input logic sub,
                          output logic [63:0] r, output logic [3:0] f,
                          output int lat);
        int guard;
        guard = 0;
        while (!start_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        a = x;
        b = y;
        op_sub = sub;
        start_valid = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            start_valid = 1'b0;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            op_sub = $urandom_range(0, 1);
        end while (!res_valid && lat < 50);
        checks++;
        if (!res_valid) begin
            errors++;
            $display("FAIL timeout: res_valid never rose (waited %0d)", lat);
        end
        r = result;
        f = {flag_c, flag_v, flag_z, flag_n};
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({start_ready, res_valid, busy} !== 3'b100 || result !== 64'd0 ||
            {flag_c, flag_v, flag_z, flag_n} !== 4'b0000) begin
            errors++;
            $display("FAIL reset: rdy/vld/busy=%b result=%h flags=%b, want 100 0 0000",
                     {start_ready, res_valid, busy}, result,
                     {flag_c, flag_v, flag_z, flag_n});
        end
        checks++;
        if ({s_start_ready, s_res_valid, s_busy} !== 3'b100 || s_result !== 16'd0) begin
            errors++;
            $display("FAIL reset_w1: rdy/vld/busy=%b result=%h, want 100 0",
                     {s_start_ready, s_res_valid, s_busy}, s_result);
        end
    endtask

    task automatic test_directed();
        logic [63:0] xs [6];
        logic [63:0] ys [6];
        logic        ss [6];
        logic [63:0] er [6];
        logic [3:0]  ef [6];
        logic [63:0] r;
        logic [3:0]  f;
        int lat;
        xs[0] = 64'h0000_0000_0000_FFFF; ys[0] = 64'd1; ss[0] = 0;
        er[0] = 64'h0000_0000_0001_0000; ef[0] = 4'b0000;
        xs[1] = 64'h7FFF_FFFF_FFFF_FFFF; ys[1] = 64'd1; ss[1] = 0;
        er[1] = 64'h8000_0000_0000_0000; ef[1] = 4'b0101;
        xs[2] = 64'h1234_5678_9ABC_DEF0; ys[2] = 64'h1234_5678_9ABC_DEF0; ss[2] = 1;
        er[2] = 64'd0;                   ef[2] = 4'b1010;
        xs[3] = 64'd0;                   ys[3] = 64'd1; ss[3] = 1;
        er[3] = 64'hFFFF_FFFF_FFFF_FFFF; ef[3] = 4'b0001;
        xs[4] = 64'hFFFF_FFFF_FFFF_FFFF; ys[4] = 64'd1; ss[4] = 0;
        er[4] = 64'd0;                   ef[4] = 4'b1010;
        xs[5] = 64'h8000_0000_0000_0000; ys[5] = 64'd1; ss[5] = 1;
        er[5] = 64'h7FFF_FFFF_FFFF_FFFF; ef[5] = 4'b1100;
        for (int i = 0; i < 6; i++) begin
            run_op(xs[i], ys[i], ss[i], r, f, lat);
            checks++;
            if (r !== er[i] || f !== ef[i]) begin
                errors++;
                $display("FAIL directed[%0d]: result=%h cvzn=%b, want %h %b",
                         i, r, f, er[i], ef[i]);
            end
            checks++;
            if (lat !== 5) begin
                errors++;
                $display("FAIL latency[%0d]: got %0d, want 5", i, lat);
            end
        end
    endtask

    task automatic test_hold();
        logic [63:0] er, r;
        logic [3:0]  ef, f;
        int guard, bad, lat;
        model(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0, er, ef);
        a = 64'h0123_4567_89AB_CDEF;
        b = 64'h1111_2222_3333_4444;
        op_sub = 1'b0;
        start_valid = 1'b1;
        @(posedge clk); #1;
        guard = 0;
        while (!res_valid && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (result !== er || {flag_c, flag_v, flag_z, flag_n} !== ef ||
                start_ready !== 1'b0 || res_valid !== 1'b1 || busy !== 1'b1)
                bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold: %0d bad cycles, result=%h want %h vld=%b rdy=%b",
                     bad, result, er, res_valid, start_ready);
        end
        start_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        checks++;
        if (start_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 ||
            result !== er) begin
            errors++;
            $display("FAIL release: rdy=%b vld=%b busy=%b result=%h, want 1 0 0 %h",
                     start_ready, res_valid, busy, result, er);
        end
        run_op(64'd100, 64'd58, 1'b1, r, f, lat);
        checks++;
        if (r !== 64'd42 || f !== 4'b1000) begin
            errors++;
            $display("FAIL after_hold: result=%h cvzn=%b, want 2a 1000", r, f);
        end
    endtask

    task automatic test_reset_midop();
        logic [63:0] r;
        logic [3:0]  f;
        int lat;
        a = 64'hAAAA_BBBB_CCCC_DDDD;
        b = 64'h1111_1111_1111_1111;
        op_sub = 1'b0;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (start_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 ||
            result !== 64'd0 || {flag_c, flag_v, flag_z, flag_n} !== 4'b0000) begin
            errors++;
            $display("FAIL midop_reset: rdy=%b vld=%b busy=%b result=%h",
                     start_ready, res_valid, busy, result);
        end
        run_op(64'd5, 64'd7, 1'b0, r, f, lat);
        checks++;
        if (r !== 64'd12 || f !== 4'b0000 || lat !== 5) begin
            errors++;
            $display("FAIL post_reset_op: result=%h cvzn=%b lat=%0d, want c 0000 5",
                     r, f, lat);
        end
    endtask

    task automatic test_random();
        logic [63:0] x, y, er, r;
        logic [3:0]  ef, f;
        logic        s;
        int lat;
        for (int i = 0; i < 30; i++) begin
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0: y = ~x + 64'(($urandom_range(0, 2)));
                1: y = x;
                2: x = {1'b0, {63{1'b1}}};
                default: ;
            endcase
            s = $urandom_range(0, 1);
            model(x, y, s, er, ef);
            run_op(x, y, s, r, f, lat);
            checks++;
            if (r !== er || f !== ef || lat !== 5) begin
                errors++;
                $display("FAIL random[%0d]: %h %s %h -> %h cvzn=%b lat=%0d, want %h %b 5",
                         i, x, s ? "-" : "+", y, r, f, lat, er, ef);
            end
        end
    endtask

    task automatic test_words1();
        logic [15:0] xs [2];
        logic [15:0] ys [2];
        logic [15:0] er [2];
        logic [3:0]  ef [2];
        int lat;
        xs[0] = 16'hFFFF; ys[0] = 16'h0001; er[0] = 16'h0000; ef[0] = 4'b1010;
        xs[1] = 16'h7FFF; ys[1] = 16'h0001; er[1] = 16'h8000; ef[1] = 4'b0101;
        for (int i = 0; i < 2; i++) begin
            s_a = xs[i];
            s_b = ys[i];
            s_op_sub = 1'b0;
            s_start_valid = 1'b1;
            lat = 0;
            do begin
                @(posedge clk); #1;
                lat++;
                s_start_valid = 1'b0;
                s_a = 16'($urandom);
            end while (!s_res_valid && lat < 20);
            checks++;
            if (s_result !== er[i] ||
                {s_flag_c, s_flag_v, s_flag_z, s_flag_n} !== ef[i] || lat !== 2) begin
                errors++;
                $display("FAIL words1[%0d]: result=%h cvzn=%b lat=%0d, want %h %b 2",
                         i, s_result, {s_flag_c, s_flag_v, s_flag_z, s_flag_n},
                         lat, er[i], ef[i]);
            end
            s_res_ready = 1'b1;
            @(posedge clk); #1;
            s_res_ready = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        start_valid = 1'b0;
        op_sub = 1'b0;
        a = '0;
        b = '0;
        res_ready = 1'b0;
        s_start_valid = 1'b0;
        s_op_sub = 1'b0;
        s_a = '0;
        s_b = '0;
        s_res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        test_directed();
        test_hold();
        test_reset_midop();
        test_random();
        test_words1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
